// File: rtl/input_and_mar.sv
// input_and_mar: SAP-1 memory address register with front-panel switch override
module input_and_mar #(
    parameter int ADDR_W = 4
) (
    output logic [ADDR_W-1:0] out,
    input  logic              clk,
    input  logic              lm,
    input  logic              prog,
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] in,
    input  logic              clr
);
    logic [ADDR_W-1:0] mar;
    // capture the W-bus address on lm; clr clears immediately and keeps loads out while high
    always_ff @(posedge clk or posedge clr)
        if (clr) mar <= '0;
        else if (lm) mar <= a;
    // program mode hands the RAM address lines to the switches; mar keeps loading underneath
    always_comb out = prog ? in : mar;
endmodule

// File: tb/tb_input_and_mar.sv
// tb_input_and_mar: directed scoreboard bench for the SAP-1 MAR / switch mux
module tb_input_and_mar;
    logic       clk = 0;
    logic       clr, lm, prog;
    logic [3:0] a, in, out;
    logic [3:0] exp_q[$];
    string      nm_q[$];
    int         checks = 0, errors = 0;
    event       smp;

    input_and_mar #(.ADDR_W(4)) dut (
        .out(out), .clk(clk), .lm(lm), .prog(prog), .a(a), .in(in), .clr(clr)
    );

    always #5 clk = ~clk;

    // queue an expected output and ask the monitor to sample now
    task automatic chk(input string nm, input logic [3:0] e);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        ->smp;
        #1;
    endtask

    // monitor: pop the oldest expectation and compare with the live output
    initial forever begin
        @(smp);
        if (exp_q.size() != 0) begin
            logic [3:0] e;
            string n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL %s: out=%0d expected=%0d at %0t", n, out, e, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 1; prog = 0; a = 4'd9; lm = 1; in = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_hold", 4'd0);
        end
        @(negedge clk); clr = 0;
        @(posedge clk); #1;
        chk("first_load_after_reset", 4'd9);
        // clear asynchronously, then hold with lm low while a wanders
        @(negedge clk); clr = 1; #1;
        chk("async_clear", 4'd0);
        clr = 0; lm = 0; a = 4'd0;
        for (int i = 0; i < 5; i++) begin
            a = a + 4'd2; #1;
            chk("hold_lm_low", 4'd0);
        end
        // program mode: out follows switches combinationally, including the 15->0 wrap
        prog = 1;
        for (int i = 0; i < 17; i++) begin
            in = 4'(i); #1;
            chk("prog_tracks_in", 4'(i));
        end
        // load while in program mode stays hidden until prog drops
        @(negedge clk); lm = 1; a = 4'd6; in = 4'd3;
        @(posedge clk); #1;
        chk("prog_hides_mar", 4'd3);
        @(negedge clk); lm = 0; prog = 0; #1;
        chk("prog_exit_shows_mar", 4'd6);
        // run-mode loads step 2,4,6; mid-cycle a changes must not leak through
        @(negedge clk); lm = 1; a = 4'd2;
        @(posedge clk); #1;
        chk("run_load_2", 4'd2);
        @(negedge clk); a = 4'd4; #1;
        chk("a_between_edges", 4'd2);
        @(posedge clk); #1;
        chk("run_load_4", 4'd4);
        @(negedge clk); a = 4'd6;
        @(posedge clk); #1;
        chk("run_load_6", 4'd6);
        @(negedge clk); lm = 0; a = 4'd15;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("frozen_after_lm_drop", 4'd6);
        end
        // async reset mid-operation, then normal reload
        @(negedge clk); lm = 1; a = 4'd10;
        @(posedge clk); #1;
        chk("load_10", 4'd10);
        @(negedge clk); lm = 0; #1; clr = 1; #1;
        chk("clr_between_edges", 4'd0);
        lm = 1; a = 4'd7;
        @(posedge clk); #1;
        chk("clr_beats_lm_edge", 4'd0);
        @(negedge clk); clr = 0; a = 4'd5;
        @(posedge clk); #1;
        chk("reload_after_clr", 4'd5);
        #5;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
            errors += exp_q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
